// File: rtl/mmio_reg_responder_pkg.sv
// mmio_pkg: shared constants for the MMIO register-page responder.
//   - REG_* : byte offsets of each register inside the 4K page
//   - SEL_* : bit positions of each select inside the internal select vector;
//             a lower index means a higher priority
//   - KBD_NE / KBD_OVF : flag bit positions in the keyboard read word
//   - DMA_START_BIT : wdata bit that fires the DMA start pulse
//   - first_sel() : keeps only the highest-priority (lowest-index) select
package mmio_pkg;

  localparam logic [11:0] REG_VGA    = 12'h000;
  localparam logic [11:0] REG_CURSOR = 12'h004;
  localparam logic [11:0] REG_SWITCH = 12'h008;
  localparam logic [11:0] REG_LED    = 12'h00c;
  localparam logic [11:0] REG_SEG    = 12'h010;
  localparam logic [11:0] REG_KBD    = 12'h014;
  localparam logic [11:0] REG_DMA    = 12'h018;

  localparam int NUM_SEL    = 7;
  localparam int SEL_VGA    = 0;
  localparam int SEL_CURSOR = 1;
  localparam int SEL_SWITCH = 2;
  localparam int SEL_LED    = 3;
  localparam int SEL_SEG    = 4;
  localparam int SEL_KBD    = 5;
  localparam int SEL_DMA    = 6;

  localparam int KBD_NE        = 31;
  localparam int KBD_OVF       = 30;
  localparam int DMA_START_BIT = 0;

  typedef logic [NUM_SEL-1:0] sel_vec_t;

  // Two's-complement trick: s & -s isolates the lowest set bit.
  function automatic sel_vec_t first_sel(input sel_vec_t s);
    return s & (~s + sel_vec_t'(1));
  endfunction

endpackage

// File: rtl/mmio_reg_responder_if.sv
// mmio_reg_responder_if: CPU-side register-page bus.
//   master : drives the decoded selects, rd/wr strobes and wdata
//   slave  : returns rdata/rvalid and the acc_err pulse
interface mmio_reg_responder_if;
  logic        en_vga_reg;
  logic        en_cursor_reg;
  logic        en_switch;
  logic        en_led;
  logic        en_seg;
  logic        en_keyboard;
  logic        en_dma;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        acc_err;

  modport master (
    output en_vga_reg, en_cursor_reg, en_switch, en_led, en_seg, en_keyboard, en_dma,
    output rd, wr, wdata,
    input  rdata, rvalid, acc_err
  );

  modport slave (
    input  en_vga_reg, en_cursor_reg, en_switch, en_led, en_seg, en_keyboard, en_dma,
    input  rd, wr, wdata,
    output rdata, rvalid, acc_err
  );
endinterface

// File: rtl/mmio_reg_responder_kbd_fifo.sv
// kbd_fifo: synchronous FIFO for keyboard scancodes.
//   clk, rst  : clock, synchronous active-high reset (pointers/count cleared)
//   push_i    : write din_i; ignored when full unless a pop happens in the same cycle
//   pop_i     : drop the head entry; ignored when empty
//   head_o    : oldest entry (meaningless when empty_o)
//   count_o   : number of stored entries
//   full_o / empty_o : occupancy flags
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rp_q];

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + AW'(1);
    if (do_pop)  rp_d = rp_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/mmio_reg_responder.sv
// mmio_reg_responder: responder for the 4K register page 0x1000_0000-0x1000_0fff.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : decoded selects, rd/wr, wdata in; rdata/rvalid/acc_err out
//   sw              : raw asynchronous board switches
//   kbd_valid/code  : scancode strobe and byte from the PS/2 receiver
//   dma_busy        : DMA engine status, returned in bit 0 of the DMA read
//   vga_reg, cursor_reg, seg_data, dma_ctrl, led : register contents
//   dma_start       : one-cycle pulse after a DMA write with bit 0 set
// Build option: define MMIO_SW_DEBOUNCE_EN to add a per-bit debounce counter
// behind the 2-FF switch synchroniser; otherwise the synchroniser output is used.
module mmio_reg_responder
  import mmio_pkg::*;
#(
  parameter int KBD_DEPTH       = 8,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_reg_responder_if.slave  bus,
  input  logic [SW_W-1:0]      sw,
  input  logic                 kbd_valid,
  input  logic [7:0]           kbd_code,
  input  logic                 dma_busy,
  output logic [31:0]          vga_reg,
  output logic [31:0]          cursor_reg,
  output logic [31:0]          seg_data,
  output logic [31:0]          dma_ctrl,
  output logic [SW_W-1:0]      led,
  output logic                 dma_start
);

  // ---------------- access decode ----------------
  sel_vec_t sel, pick, wr_hit;
  logic     rd_fire, kbd_rd, acc_err_d;

  assign sel = {bus.en_dma, bus.en_keyboard, bus.en_seg, bus.en_led,
                bus.en_switch, bus.en_cursor_reg, bus.en_vga_reg};
  assign pick = first_sel(sel);

  // sel differs from its lowest set bit exactly when more than one select is high.
  assign acc_err_d = (bus.rd | bus.wr) &
                     ((bus.rd & bus.wr) | (sel == '0) | (sel != pick) |
                      (bus.wr & (sel[SEL_SWITCH] | sel[SEL_KBD])));

  // A combined rd&wr keeps the write but drops the read.
  assign rd_fire = bus.rd & ~bus.wr;
  assign wr_hit  = {NUM_SEL{bus.wr}} & pick;
  assign kbd_rd  = rd_fire & pick[SEL_KBD];

  // ---------------- switch synchroniser / debounce ----------------
  logic [SW_W-1:0] sw_meta_q, sw_sync_q, sw_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef MMIO_SW_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q [SW_W];
  logic [SW_W-1:0] sw_acc_q;

  // Down-counter per bit: reloads whenever the synced bit agrees with the
  // accepted value, accepts on the DEBOUNCE_CYCLES-th consecutive disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_acc_q <= '0;
      for (int i = 0; i < SW_W; i++) db_cnt_q[i] <= DB_LOAD;
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        if (sw_sync_q[i] == sw_acc_q[i]) begin
          db_cnt_q[i] <= DB_LOAD;
        end else if (db_cnt_q[i] == '0) begin
          sw_acc_q[i] <= sw_sync_q[i];
          db_cnt_q[i] <= DB_LOAD;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] - DB_W'(1);
        end
      end
    end
  end

  assign sw_val = sw_acc_q;
`else
  assign sw_val = sw_sync_q;
`endif

  // ---------------- keyboard FIFO ----------------
  logic [7:0]                 kbd_head;
  logic [$clog2(KBD_DEPTH):0] kbd_count;
  logic                       kbd_full, kbd_empty, kbd_ne, kbd_drop;

  kbd_fifo #(
    .DEPTH (KBD_DEPTH),
    .W     (8)
  ) u_kbd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (kbd_valid),
    .pop_i   (kbd_rd),
    .din_i   (kbd_code),
    .head_o  (kbd_head),
    .count_o (kbd_count),
    .full_o  (kbd_full),
    .empty_o (kbd_empty)
  );

  assign kbd_ne = (kbd_count != '0);
  // A pop only happens when nonempty, and full implies nonempty, so a keyboard
  // read in the same cycle always makes room.
  assign kbd_drop = kbd_valid & kbd_full & ~kbd_rd;

  // ---------------- registers ----------------
  logic [31:0]     vga_q, vga_d, cur_q, cur_d, seg_q, seg_d, dma_q, dma_d;
  logic [SW_W-1:0] led_q, led_d;
  logic [31:0]     rdata_q, rdata_d, rd_word, kbd_word;
  logic            rvalid_q, acc_err_q, dma_start_q, dma_start_d, ovf_q, ovf_d;

  always_comb begin
    kbd_word          = '0;
    kbd_word[KBD_NE]  = kbd_ne;
    kbd_word[KBD_OVF] = ovf_q;
    kbd_word[7:0]     = kbd_empty ? 8'h00 : kbd_head;
  end

  always_comb begin
    rd_word = '0;
    if (pick[SEL_VGA])         rd_word = vga_q;
    else if (pick[SEL_CURSOR]) rd_word = cur_q;
    else if (pick[SEL_SWITCH]) rd_word = 32'(sw_val);
    else if (pick[SEL_LED])    rd_word = 32'(led_q);
    else if (pick[SEL_SEG])    rd_word = seg_q;
    else if (pick[SEL_KBD])    rd_word = kbd_word;
    else if (pick[SEL_DMA])    rd_word = {dma_q[31:1], dma_busy};
  end

  always_comb begin
    vga_d = vga_q;
    cur_d = cur_q;
    led_d = led_q;
    seg_d = seg_q;
    dma_d = dma_q;
    if (wr_hit[SEL_VGA])    vga_d = bus.wdata;
    if (wr_hit[SEL_CURSOR]) cur_d = bus.wdata;
    if (wr_hit[SEL_LED])    led_d = bus.wdata[SW_W-1:0];
    if (wr_hit[SEL_SEG])    seg_d = bus.wdata;
    if (wr_hit[SEL_DMA])    dma_d = {bus.wdata[31:1], 1'b0};
    dma_start_d = wr_hit[SEL_DMA] & bus.wdata[DMA_START_BIT];
    rdata_d     = rd_fire ? rd_word : rdata_q;
    ovf_d = ovf_q;
    if (kbd_rd && kbd_ne) ovf_d = 1'b0;
    else if (kbd_drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_q       <= '0;
      cur_q       <= '0;
      led_q       <= '0;
      seg_q       <= '0;
      dma_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      acc_err_q   <= 1'b0;
      dma_start_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vga_q       <= vga_d;
      cur_q       <= cur_d;
      led_q       <= led_d;
      seg_q       <= seg_d;
      dma_q       <= dma_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rd_fire;
      acc_err_q   <= acc_err_d;
      dma_start_q <= dma_start_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.acc_err = acc_err_q;
  assign vga_reg     = vga_q;
  assign cursor_reg  = cur_q;
  assign seg_data    = seg_q;
  assign dma_ctrl    = dma_q;
  assign led         = led_q;
  assign dma_start   = dma_start_q;

endmodule
